// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB maintenance sequencer: entry layout,
// op encodings, INVTLB op codes and controller state encoding.
package tlb_pkg;

    localparam int ENTRY_W = 89;

    // Entry layout, MSB first: {E, ASID, G, PS, VPPN, PPN0, PLV0, MAT0, D0, V0,
    //                           PPN1, PLV1, MAT1, D1, V1}
    localparam int V1_LSB   = 0;
    localparam int D1_LSB   = 1;
    localparam int MAT1_LSB = 2;
    localparam int PLV1_LSB = 4;
    localparam int PPN1_LSB = 6;
    localparam int V0_LSB   = 26;
    localparam int D0_LSB   = 27;
    localparam int MAT0_LSB = 28;
    localparam int PLV0_LSB = 30;
    localparam int PPN0_LSB = 32;
    localparam int VPPN_LSB = 52;
    localparam int PS_LSB   = 71;
    localparam int G_BIT    = 77;
    localparam int ASID_LSB = 78;
    localparam int E_BIT    = 88;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    localparam logic [4:0] INV_ALL0       = 5'd0;
    localparam logic [4:0] INV_ALL1       = 5'd1;
    localparam logic [4:0] INV_GLOBAL     = 5'd2;
    localparam logic [4:0] INV_NONGLOBAL  = 5'd3;
    localparam logic [4:0] INV_ASID       = 5'd4;
    localparam logic [4:0] INV_ASID_VA    = 5'd5;
    localparam logic [4:0] INV_G_ASID_VA  = 5'd6;

    localparam logic [5:0] ECODE_TLBR = 6'h3F;
    localparam logic [5:0] PS_4M      = 6'd21;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC     = 2'd1,
        S_INV_WALK = 2'd2,
        S_DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/tlb_inv_match.sv
// Combinational INVTLB selection: does this entry fall under the given inv_op?
// The E bit is not examined here; the caller qualifies with it.
module tlb_inv_match
    import tlb_pkg::*;
(
    input  logic [ENTRY_W-1:0] entry,
    input  logic [4:0]         inv_op,
    input  logic [9:0]         asid,
    input  logic [31:0]        va,
    output logic               hit
);

    logic        g;
    logic        asid_eq;
    logic        va_eq;
    logic [18:0] vppn;

    assign g       = entry[G_BIT];
    assign vppn    = entry[VPPN_LSB +: 19];
    assign asid_eq = (entry[ASID_LSB +: 10] == asid);
    // 4MB pages only compare the bits above the page offset
    assign va_eq   = (entry[PS_LSB +: 6] == PS_4M) ? (vppn[18:9] == va[31:22])
                                                   : (vppn == va[31:13]);

    always_comb begin
        hit = 1'b0;
        case (inv_op)
            INV_ALL0, INV_ALL1: hit = 1'b1;
            INV_GLOBAL:         hit = g;
            INV_NONGLOBAL:      hit = ~g;
            INV_ASID:           hit = ~g & asid_eq;
            INV_ASID_VA:        hit = ~g & asid_eq & va_eq;
            INV_G_ASID_VA:      hit = (g | asid_eq) & va_eq;
            default:            hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB retiring from WB; owns the
// TLB ports while an op is in flight and requests a refetch on completion.
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [4:0]         req_inv_op,
    input  logic [9:0]         req_asid,
    input  logic [31:0]        req_va,
    input  logic [31:0]        req_pc,
    input  logic [IDXW-1:0]    csr_tlbidx_index,
    input  logic               csr_tlbidx_ne,
    input  logic [5:0]         csr_estat_ecode,
    input  logic [ENTRY_W-1:0] csr_entry_in,
    output logic [18:0]        tlb_s_vppn,
    output logic [9:0]         tlb_s_asid,
    input  logic               tlb_s_found,
    input  logic [IDXW-1:0]    tlb_s_index,
    output logic [IDXW-1:0]    tlb_r_index,
    input  logic [ENTRY_W-1:0] tlb_r_entry,
    output logic               tlb_we,
    output logic [IDXW-1:0]    tlb_w_index,
    output logic [ENTRY_W-1:0] tlb_w_entry,
    output logic               csr_srch_we,
    output logic               csr_srch_found,
    output logic [IDXW-1:0]    csr_srch_index,
    output logic               csr_rd_we,
    output logic [ENTRY_W-1:0] csr_entry_out,
    output logic               done,
    output logic               ine_ex,
    output logic               refetch_valid,
    output logic [31:0]        refetch_pc
);

    state_e            state, state_nxt;
    logic [2:0]        op_q;
    logic [4:0]        inv_op_q;
    logic [9:0]        asid_q;
    logic [31:0]       va_q;
    logic [31:0]       pc_q;
    logic              ine_q;
    logic [IDXW-1:0]   fill_cnt;
    logic [IDXW-1:0]   walk_idx;
    logic              inv_hit;
    logic              req_ine;
    logic [ENTRY_W-1:0] wr_entry;

    tlb_inv_match u_match (
        .entry  (tlb_r_entry),
        .inv_op (inv_op_q),
        .asid   (asid_q),
        .va     (va_q),
        .hit    (inv_hit)
    );

    assign req_ine = !((req_op <= OP_FILL) || (req_op == OP_INV && req_inv_op <= INV_G_ASID_VA));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            op_q     <= '0;
            inv_op_q <= '0;
            asid_q   <= '0;
            va_q     <= '0;
            pc_q     <= '0;
            ine_q    <= 1'b0;
            fill_cnt <= '0;
            walk_idx <= '0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= fill_cnt + IDXW'(1);
            if (state == S_IDLE && req_valid) begin
                op_q     <= req_op;
                inv_op_q <= req_inv_op;
                asid_q   <= req_asid;
                va_q     <= req_va;
                pc_q     <= req_pc;
                ine_q    <= req_ine;
                walk_idx <= '0;
            end else if (state == S_INV_WALK) begin
                walk_idx <= walk_idx + IDXW'(1);
            end
        end
    end

    // TLBWR/TLBFILL: refill exceptions always install a valid entry
    always_comb begin
        wr_entry        = csr_entry_in;
        wr_entry[E_BIT] = (csr_estat_ecode == ECODE_TLBR) ? 1'b1 : ~csr_tlbidx_ne;
    end

    assign tlb_s_vppn     = csr_entry_in[VPPN_LSB +: 19];
    assign tlb_s_asid     = csr_entry_in[ASID_LSB +: 10];
    assign csr_srch_found = tlb_s_found;
    assign csr_srch_index = tlb_s_found ? tlb_s_index : '0;
    assign csr_entry_out  = tlb_r_entry[E_BIT] ? tlb_r_entry : '0;
    assign refetch_pc     = pc_q + 32'd4;

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        tlb_r_index   = walk_idx;
        tlb_we        = 1'b0;
        tlb_w_index   = walk_idx;
        tlb_w_entry   = wr_entry;
        csr_srch_we   = 1'b0;
        csr_rd_we     = 1'b0;
        done          = 1'b0;
        ine_ex        = 1'b0;
        refetch_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_ine)               state_nxt = S_DONE;
                    else if (req_op == OP_INV) state_nxt = S_INV_WALK;
                    else                       state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nxt = S_DONE;
                case (op_q)
                    OP_SRCH: csr_srch_we = 1'b1;
                    OP_RD: begin
                        tlb_r_index = csr_tlbidx_index;
                        csr_rd_we   = 1'b1;
                    end
                    OP_WR: begin
                        tlb_we      = 1'b1;
                        tlb_w_index = csr_tlbidx_index;
                    end
                    OP_FILL: begin
                        tlb_we      = 1'b1;
                        tlb_w_index = fill_cnt;
                    end
                    default: ;
                endcase
            end
            S_INV_WALK: begin
                tlb_w_entry        = tlb_r_entry;
                tlb_w_entry[E_BIT] = 1'b0;
                tlb_we             = tlb_r_entry[E_BIT] & inv_hit;
                if (walk_idx == IDXW'(TLBNUM - 1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                done          = 1'b1;
                ine_ex        = ine_q;
                refetch_valid = ~ine_q;
                state_nxt     = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a behavioural 16-entry TLB read port.
module tb_tlb_op_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [4:0]  req_inv_op = '0;
    logic [9:0]  req_asid = '0;
    logic [31:0] req_va = '0;
    logic [31:0] req_pc = '0;
    logic [3:0]  csr_tlbidx_index = '0;
    logic        csr_tlbidx_ne = 1'b0;
    logic [5:0]  csr_estat_ecode = '0;
    logic [88:0] csr_entry_in = '0;
    logic [18:0] tlb_s_vppn;
    logic [9:0]  tlb_s_asid;
    logic        tlb_s_found = 1'b0;
    logic [3:0]  tlb_s_index = '0;
    logic [3:0]  tlb_r_index;
    logic [88:0] tlb_r_entry;
    logic        tlb_we;
    logic [3:0]  tlb_w_index;
    logic [88:0] tlb_w_entry;
    logic        csr_srch_we, csr_srch_found;
    logic [3:0]  csr_srch_index;
    logic        csr_rd_we;
    logic [88:0] csr_entry_out;
    logic        done, ine_ex, refetch_valid;
    logic [31:0] refetch_pc;

    logic [88:0] mem [16];
    int n_cmp = 0;
    int n_err = 0;

    assign tlb_r_entry = mem[tlb_r_index];

    always #5 clk = ~clk;

    tlb_op_ctrl #(.TLBNUM(16)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_inv_op(req_inv_op), .req_asid(req_asid), .req_va(req_va), .req_pc(req_pc),
        .csr_tlbidx_index(csr_tlbidx_index), .csr_tlbidx_ne(csr_tlbidx_ne),
        .csr_estat_ecode(csr_estat_ecode), .csr_entry_in(csr_entry_in),
        .tlb_s_vppn(tlb_s_vppn), .tlb_s_asid(tlb_s_asid),
        .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
        .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
        .csr_srch_we(csr_srch_we), .csr_srch_found(csr_srch_found),
        .csr_srch_index(csr_srch_index), .csr_rd_we(csr_rd_we),
        .csr_entry_out(csr_entry_out), .done(done), .ine_ex(ine_ex),
        .refetch_valid(refetch_valid), .refetch_pc(refetch_pc)
    );

    function automatic logic [88:0] mk(input logic e, input logic [9:0] asid, input logic g,
                                       input logic [5:0] ps, input logic [18:0] vppn,
                                       input logic [51:0] lo);
        return {e, asid, g, ps, vppn, lo};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns sampled in the cycle after acceptance.
    task automatic issue(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] asid,
                         input logic [31:0] va, input logic [31:0] pc);
        chk("ready_before_issue", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_inv_op = iop;
        req_asid = asid; req_va = va; req_pc = pc;
        tick;
        req_valid = 1'b0;
    endtask

    // Observe a full walk (T+1..T+16) and the done cycle at T+17.
    task automatic walk(input logic [31:0] pc, output int nwr, output logic [15:0] mask);
        nwr = 0;
        mask = '0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick;
            if (tlb_we) begin
                nwr++;
                mask[tlb_w_index] = 1'b1;
                chk("inv_wr_e", tlb_w_entry[88], 0);
                chk("inv_wr_rest", tlb_w_entry[87:0], mem[i][87:0]);
            end
        end
        tick;
        chk("inv_done", done, 1);
        chk("inv_refetch", {refetch_valid, refetch_pc}, {1'b1, pc + 32'd4});
    endtask

    initial begin
        int nwr;
        logic [15:0] mask;
        logic [3:0] fidx;
        int cnt;

        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[2]  = mk(1, 10'h012, 0, 6'd12, 19'h00201, 52'h1111_2222_3333);
        mem[4]  = mk(0, 10'h012, 1, 6'd12, 19'h00201, 52'h4);
        mem[9]  = mk(1, 10'h012, 1, 6'd12, 19'h00201, 52'h9);
        mem[11] = mk(1, 10'h013, 0, 6'd21, {10'h001, 9'h1FF}, 52'hB);

        tick; tick;
        chk("rst_ready", req_ready, 1);
        chk("rst_pulses", {tlb_we, csr_srch_we, csr_rd_we, done, ine_ex, refetch_valid}, 0);
        resetn = 1'b1;
        tick;

        // TLBSRCH hit
        tlb_s_found = 1'b1; tlb_s_index = 4'd5;
        issue(3'd0, 5'd0, 10'h0, 32'h0, 32'h1C00_0100);
        chk("srch_we", {csr_srch_we, csr_srch_found, csr_srch_index}, {1'b1, 1'b1, 4'd5});
        chk("srch_busy", {req_ready, tlb_we, done}, 0);
        tick;
        chk("srch_done", {done, refetch_valid, csr_srch_we}, 3'b110);
        chk("srch_pc", refetch_pc, 32'h1C00_0104);
        tick;
        chk("srch_idle", {req_ready, done}, 2'b10);

        // TLBSRCH miss reports index 0
        tlb_s_found = 1'b0; tlb_s_index = 4'd7;
        issue(3'd0, 5'd0, 10'h0, 32'h0, 32'h2000);
        chk("srch_miss", {csr_srch_we, csr_srch_found, csr_srch_index}, {1'b1, 1'b0, 4'd0});
        tick; tick;

        // TLBRD valid and invalid entries
        csr_tlbidx_index = 4'd9;
        issue(3'd1, 5'd0, 10'h0, 32'h0, 32'h3000);
        chk("rd_idx", tlb_r_index, 9);
        chk("rd_out", {csr_rd_we, csr_entry_out}, {1'b1, mem[9]});
        tick; tick;
        csr_tlbidx_index = 4'd4;
        issue(3'd1, 5'd0, 10'h0, 32'h0, 32'h3000);
        chk("rd_zero", {csr_rd_we, csr_entry_out}, {1'b1, 89'h0});
        tick; tick;

        // TLBWR: refill ecode forces E=1 despite NE=1, otherwise E=~NE
        csr_entry_in = mk(0, 10'h055, 0, 6'd12, 19'h01234, 52'hA_BCDE_F012_3456);
        csr_tlbidx_index = 4'd3; csr_tlbidx_ne = 1'b1; csr_estat_ecode = 6'h3F;
        issue(3'd2, 5'd0, 10'h0, 32'h0, 32'h4000);
        chk("wr_tlbr", {tlb_we, tlb_w_index, tlb_w_entry},
            {1'b1, 4'd3, mk(1, 10'h055, 0, 6'd12, 19'h01234, 52'hA_BCDE_F012_3456)});
        chk("srch_key", {tlb_s_vppn, tlb_s_asid}, {19'h01234, 10'h055});
        tick;
        chk("wr_single", tlb_we, 0);
        tick;
        csr_estat_ecode = 6'h00;
        issue(3'd2, 5'd0, 10'h0, 32'h0, 32'h4000);
        chk("wr_ne", {tlb_we, tlb_w_index, tlb_w_entry[88]}, {1'b1, 4'd3, 1'b0});
        tick; tick;

        // TLBFILL twice, 7 cycles apart
        csr_tlbidx_ne = 1'b0;
        issue(3'd3, 5'd0, 10'h0, 32'h0, 32'h5000);
        fidx = tlb_w_index;
        chk("fill_we", {tlb_we, tlb_w_entry[88]}, 2'b11);
        tick; tick;
        tick; tick; tick; tick;
        issue(3'd3, 5'd0, 10'h0, 32'h0, 32'h5000);
        chk("fill_delta", tlb_w_index, fidx + 4'd7);
        tick; tick;

        // INVTLB op5: only entry 2 (G=0, ASID match, VA match)
        issue(3'd4, 5'd5, 10'h012, 32'h0040_2000, 32'h6000);
        walk(32'h6000, nwr, mask);
        chk("inv5_mask", {nwr[7:0], mask}, {8'd1, 16'h0004});
        tick;
        // INVTLB op2: global entries with E=1 only (9, not 4)
        issue(3'd4, 5'd2, 10'h000, 32'h0, 32'h6100);
        walk(32'h6100, nwr, mask);
        chk("inv2_mask", {nwr[7:0], mask}, {8'd1, 16'h0200});
        tick;
        // INVTLB op6: 4MB page at entry 11 via ASID match
        issue(3'd4, 5'd6, 10'h013, 32'h0040_0000, 32'h6200);
        walk(32'h6200, nwr, mask);
        chk("inv6_mask", {nwr[7:0], mask}, {8'd1, 16'h0800});
        tick;

        // Invalid INVTLB op
        issue(3'd4, 5'd9, 10'h0, 32'h0, 32'h7000);
        chk("ine_pulse", {done, ine_ex, refetch_valid, tlb_we}, 4'b1100);
        tick;
        chk("ine_idle", {req_ready, done, ine_ex}, 3'b100);

        // Reset in the middle of a walk
        issue(3'd4, 5'd0, 10'h0, 32'h0, 32'h8000);
        cnt = 0;
        while (tlb_r_index != 4'd6 && cnt < 20) begin
            tick;
            cnt++;
        end
        chk("walk_reach6", tlb_r_index, 6);
        resetn = 1'b0;
        tick;
        chk("rst_walk_ready", {req_ready, tlb_we}, 2'b10);
        resetn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (tlb_we || done) cnt++;
        end
        chk("rst_walk_quiet", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Multi-cycle sequencer for the LoongArch TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) retiring from the WB stage. It owns the TLB array's read, write and search ports while an op is in flight and returns TLB results to the CSR file. On completion it raises a refetch pulse so the front end restarts at the instruction after the op. INVTLB is executed as a one-entry-per-cycle walk over the array.

## Interface
- TLBNUM, 16, number of TLB entries (power of 2)
- IDXW, $clog2(TLBNUM), index width
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- req_valid  in  1  WB presents a TLB op
- req_ready  out  1  controller idle, accepts op
- req_op  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5–7 not issued
- req_inv_op  in  5  INVTLB op field
- req_asid  in  10  INVTLB rj[9:0]
- req_va  in  32  INVTLB rk
- req_pc  in  32  PC of the op
- csr_tlbidx_index  in  IDXW  TLBIDX.Index
- csr_tlbidx_ne  in  1  TLBIDX.NE
- csr_estat_ecode  in  6  ESTAT.Ecode
- csr_entry_in  in  ENTRY_W  entry assembled from TLBEHI/TLBELO0/1/ASID/TLBIDX.PS
- tlb_s_vppn / tlb_s_asid  out  19 / 10  search key (from csr_entry_in)
- tlb_s_found / tlb_s_index  in  1 / IDXW  combinational search result
- tlb_r_index  out  IDXW  read index; tlb_r_entry  in  ENTRY_W  combinational read data
- tlb_we  out  1; tlb_w_index  out  IDXW; tlb_w_entry  out  ENTRY_W  write port
- csr_srch_we  out  1; csr_srch_found  out  1; csr_srch_index  out  IDXW  TLBSRCH result
- csr_rd_we  out  1; csr_entry_out  out  ENTRY_W  TLBRD result
- done  out  1  op complete pulse
- ine_ex  out  1  INVTLB op invalid pulse
- refetch_valid  out  1; refetch_pc  out  32  restart at refetch_pc

## Operation
- States: IDLE, EXEC, INV_WALK, DONE. Reset → IDLE.
- IDLE: req_ready=1; on req_valid capture op, inv_op, asid, va, pc → EXEC if op∈{0..3}, INV_WALK if op=4 and inv_op≤6, else DONE with ine pending.
- EXEC (one cycle): SRCH: csr_srch_we=1, found=tlb_s_found, index=tlb_s_found?tlb_s_index:0. RD: tlb_r_index=csr_tlbidx_index; csr_rd_we=1; csr_entry_out=tlb_r_entry if its E=1, else all-zero (CSR sets NE=1 from E=0). WR: tlb_we=1, index=csr_tlbidx_index. FILL: tlb_we=1, index=fill_cnt. Written entry = csr_entry_in with E = (csr_estat_ecode==6'h3F) ? 1 : ~csr_tlbidx_ne. → DONE.
- INV_WALK: walk_idx 0→TLBNUM-1, tlb_r_index=walk_idx; if entry E=1 and match(inv_op) then tlb_we=1, same index, entry with E cleared. After TLBNUM-1 → DONE.
- Match: op0/1 all; op2 G=1; op3 G=0; op4 G=0 & ASID==asid; op5 G=0 & ASID==asid & VA; op6 (G=1 | ASID==asid) & VA. VA match: PS=21 compares vppn[18:9] with va[31:22]; else vppn with va[31:13].
- DONE (one cycle): done=1; refetch_valid=1, refetch_pc=pc+4, except invalid inv_op: ine_ex=1, refetch_valid=0. → IDLE.
- fill_cnt: free-running IDXW counter, +1 every cycle, wraps TLBNUM-1→0.

## Timing
- Reset: state IDLE, fill_cnt=0, walk_idx=0, captured regs 0; all we/pulse outputs 0, req_ready=1.
- Accept at cycle T; SRCH/RD/WR/FILL action at T+1, done at T+2, req_ready again at T+3.
- INVTLB: writes at T+1..T+TLBNUM, done at T+TLBNUM+1.
- Invalid inv_op: done+ine_ex at T+1, no TLB write.
- req_ready=0 outside IDLE; req_valid ignored there. Request fields sampled only at acceptance; csr_* inputs sampled live in EXEC.
- At most one tlb_we per cycle; csr_srch_we, csr_rd_we, done, ine_ex, refetch_valid are single-cycle pulses.
- resetn low mid-walk: next cycle IDLE, no further writes; partially invalidated entries stay invalidated.

## Structure
- tlb_pkg: ENTRY_W (89), entry field offsets {E, ASID, G, PS, VPPN, PPN0, PLV0, MAT0, D0, V0, PPN1, PLV1, MAT1, D1, V1}, op encodings, INVTLB op codes, ECODE_TLBR=6'h3F, state encoding.
- Sub-module tlb_inv_match: combinational match(entry, inv_op, asid, va).

## Test plan
- TLBSRCH hit: tlb_s_found=1, index 5 → T+1 csr_srch_we=1, found=1, index=5; T+2 done, refetch_pc=req_pc+4.
- TLBWR NE=1, ecode=0x3F, index 3 → tlb_we at T+1, index 3, E=1; ecode=0 → E=0.
- TLBFILL issued twice 7 cycles apart → indices differ by 7 mod 16.
- INVTLB op5 asid=0x12 va=0x0040_2000, entries 2 (G=0, ASID 0x12, PS12, VPPN match) and 9 (G=1) → only entry 2 written, E=0; done at T+17.
- INVTLB op 9 → T+1 done=1, ine_ex=1, refetch_valid=0, no tlb_we.
- resetn low at walk index 6 → no tlb_we after, req_ready=1 following cycle.
